// File: rtl/neural_pkg.sv
// ============================================================================
// neural_pkg : shared types and constants for the neural result display path
// Rev 1.0
// ============================================================================
`default_nettype none

package neural_pkg;

  // Scores are signed Q4.12: 4 integer bits (sign included), 12 fraction bits
  localparam int Q_INT_BITS  = 4;
  localparam int Q_FRAC_BITS = 12;
  localparam int Q_WIDTH     = Q_INT_BITS + Q_FRAC_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESOLVE = 2'd2
  } ctrl_state_t;

  localparam logic [3:0] DIGIT_NONE = 4'hA;

  // Segment order {dp,g,f,e,d,c,b,a}, active-high
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

`default_nettype wire

// File: rtl/seven_seg_enc.sv
// ============================================================================
// seven_seg_enc : combinational digit to seven-segment pattern; non-digits blank
// Rev 1.0
// ============================================================================
`default_nettype none

module seven_seg_enc
  import neural_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/neural_result_ctrl.sv
// ============================================================================
// neural_result_ctrl : streams class scores, tracks thresholded argmax, drives display
// Rev 1.0
// ============================================================================
`default_nettype none

module neural_result_ctrl
  import neural_pkg::*;
#(
  parameter logic signed [15:0] THRESH      = 16'sh0400,
  parameter int                 TIMEOUT     = 64,
  parameter int                 NUM_CLASSES = 10
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      start,
  input  logic                      clear,
  input  logic                      score_valid,
  input  logic signed [Q_WIDTH-1:0] score_data,
  output logic                      score_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      abort,
  output logic [3:0]                digit,
  output logic                      digit_valid,
  output logic [7:0]                seven_seg
);

  localparam int         WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [3:0] c_IDX_LAST = 4'(NUM_CLASSES - 1);
  localparam logic [WD_W-1:0] c_WD_LAST = WD_W'(TIMEOUT - 1);

  ctrl_state_t               r_state;
  logic [3:0]                r_idx;
  logic signed [Q_WIDTH-1:0] r_best_val;
  logic [3:0]                r_best_idx;
  logic                      r_have;
  logic [WD_W-1:0]           r_wdog;
  logic                      r_done;
  logic                      r_abort;
  logic [3:0]                r_digit;
  logic [7:0]                r_seg;
  logic                      r_digit_valid;

  logic       w_beat;
  logic       w_eligible;
  logic [3:0] w_res_digit;
  logic [7:0] w_res_seg;

  assign w_beat      = score_valid && (r_state == COLLECT);
  // Strict compare against the incumbent keeps the lower index on ties
  assign w_eligible  = (score_data > THRESH) && (!r_have || (score_data > r_best_val));
  assign w_res_digit = r_have ? r_best_idx : DIGIT_NONE;

  seven_seg_enc u_enc (
    .i_digit (w_res_digit),
    .o_seg   (w_res_seg)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_best_val    <= '0;
      r_best_idx    <= '0;
      r_have        <= 1'b0;
      r_wdog        <= '0;
      r_done        <= 1'b0;
      r_abort       <= 1'b0;
      r_digit       <= DIGIT_NONE;
      r_seg         <= SEG_BLANK;
      r_digit_valid <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;

      if (clear) begin
        r_digit       <= DIGIT_NONE;
        r_seg         <= SEG_BLANK;
        r_digit_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_idx      <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_have     <= 1'b0;
            r_wdog     <= '0;
            r_state    <= COLLECT;
          end
        end

        COLLECT: begin
          if (start) begin
            r_idx      <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_have     <= 1'b0;
            r_wdog     <= '0;
          end else if (w_beat) begin
            if (w_eligible) begin
              r_best_val <= score_data;
              r_best_idx <= r_idx;
              r_have     <= 1'b1;
            end
            r_idx  <= r_idx + 4'd1;
            r_wdog <= '0;
            if (r_idx == c_IDX_LAST) r_state <= RESOLVE;
          end else if (r_wdog == c_WD_LAST) begin
            r_abort <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end

        // Placed after the clear handling so a fresh result overrides it
        RESOLVE: begin
          r_digit       <= w_res_digit;
          r_seg         <= w_res_seg;
          r_digit_valid <= 1'b1;
          r_done        <= 1'b1;
          r_state       <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign score_ready = (r_state == COLLECT);
  assign busy        = (r_state == COLLECT) || (r_state == RESOLVE);
  assign done        = r_done;
  assign abort       = r_abort;
  assign digit       = r_digit;
  assign digit_valid = r_digit_valid;
  assign seven_seg   = r_seg;

endmodule

`default_nettype wire

// File: tb/tb_neural_result_ctrl.sv
// ============================================================================
// tb_neural_result_ctrl : table-driven self-checking bench for neural_result_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_neural_result_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic        clear;
  logic        score_valid;
  logic [15:0] score_data;
  logic        score_ready;
  logic        busy;
  logic        done;
  logic        abort;
  logic [3:0]  digit;
  logic        digit_valid;
  logic [7:0]  seven_seg;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0][15:0] sc;
    logic [3:0]       dig;
    logic [7:0]       seg;
  } vec_t;

  vec_t tbl [11];

  always #5 clk = ~clk;

  neural_result_ctrl dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .clear       (clear),
    .score_valid (score_valid),
    .score_data  (score_data),
    .score_ready (score_ready),
    .busy        (busy),
    .done        (done),
    .abort       (abort),
    .digit       (digit),
    .digit_valid (digit_valid),
    .seven_seg   (seven_seg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic v, input logic [15:0] d);
    start       = 1'b1;
    score_valid = v;
    score_data  = d;
    @(negedge clk);
    start       = 1'b0;
    score_valid = 1'b0;
    chk("ready_after_start", {31'd0, score_ready}, 32'd1);
  endtask

  task automatic send_beats(input logic [9:0][15:0] sc, input int n);
    for (int i = 0; i < n; i++) begin
      score_valid = 1'b1;
      score_data  = sc[i];
      @(negedge clk);
    end
    score_valid = 1'b0;
    score_data  = 16'h0000;
  endtask

  // Called right after the 10th beat edge: FSM is in RESOLVE this cycle
  task automatic check_result(input string tag, input logic [3:0] ed, input logic [7:0] es,
                              input logic clr);
    chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_resolve"}, {31'd0, busy}, 32'd1);
    clear = clr;
    @(negedge clk);
    clear = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_digit"}, {28'd0, digit}, {28'd0, ed});
    chk({tag, "_seg"}, {24'd0, seven_seg}, {24'd0, es});
    chk({tag, "_dvalid"}, {31'd0, digit_valid}, 32'd1);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [9:0][15:0] sc;
    int n_abort;
    int first_abort;

    n_rst = 1'b0; start = 1'b0; clear = 1'b0; score_valid = 1'b0; score_data = '0;

    for (int k = 0; k < 11; k++) tbl[k] = '0;
    tbl[0].sc[0] = 16'h0100; tbl[0].sc[1] = 16'h0200; tbl[0].sc[2] = 16'h0300;
    tbl[0].sc[3] = 16'h0900; tbl[0].sc[4] = 16'h0500; tbl[0].dig = 4'd3; tbl[0].seg = 8'h4F;
    tbl[1].sc[2] = 16'h0800; tbl[1].sc[7] = 16'h0800; tbl[1].dig = 4'd2; tbl[1].seg = 8'h5B;
    for (int i = 0; i < 10; i++) tbl[2].sc[i] = 16'h0400;
    tbl[2].dig = 4'hA; tbl[2].seg = 8'h00;
    for (int i = 0; i < 10; i++) tbl[3].sc[i] = 16'hF000;
    tbl[3].dig = 4'hA; tbl[3].seg = 8'h00;
    tbl[4].sc[5] = 16'h0401; tbl[4].dig = 4'd5; tbl[4].seg = 8'h6D;
    for (int i = 0; i < 10; i++) tbl[5].sc[i] = 16'h1000 - 16'(i * 16'h0100);
    tbl[5].dig = 4'd0; tbl[5].seg = 8'h3F;
    tbl[6].sc[0] = 16'h7FFE; tbl[6].sc[8] = 16'h7FFF; tbl[6].dig = 4'd8; tbl[6].seg = 8'h7F;
    tbl[7].sc[1] = 16'h0500; tbl[7].sc[4] = 16'hF800; tbl[7].sc[6] = 16'h0800;
    tbl[7].dig = 4'd6; tbl[7].seg = 8'h7D;
    tbl[8].sc[1] = 16'h0401; tbl[8].sc[4] = 16'h0402; tbl[8].dig = 4'd4; tbl[8].seg = 8'h66;
    tbl[9].sc[1] = 16'h0410; tbl[9].sc[7] = 16'h0410; tbl[9].dig = 4'd1; tbl[9].seg = 8'h06;
    tbl[10].sc[7] = 16'h2000; tbl[10].dig = 4'd7; tbl[10].seg = 8'h07;

    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_digit", {28'd0, digit}, 32'hA);
    chk("rst_seg", {24'd0, seven_seg}, 32'h00);
    chk("rst_dvalid", {31'd0, digit_valid}, 32'd0);
    chk("rst_ready", {31'd0, score_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_abort", {30'd0, done, abort}, 32'd0);

    for (int k = 0; k < 11; k++) begin
      pulse_start(1'b0, 16'h0000);
      send_beats(tbl[k].sc, 10);
      check_result($sformatf("vec%0d", k), tbl[k].dig, tbl[k].seg, 1'b0);
    end

    // Watchdog: 4 beats then silence; display must keep digit 7
    pulse_start(1'b0, 16'h0000);
    send_beats(tbl[0].sc, 4);
    n_abort = 0; first_abort = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (abort) begin
        n_abort++;
        if (first_abort == 0) first_abort = i;
        chk("abort_no_done", {31'd0, done}, 32'd0);
      end
    end
    chk("abort_count", n_abort, 32'd1);
    chk("abort_cycle", first_abort, 32'd64);
    chk("abort_idle", {30'd0, score_ready, busy}, 32'd0);
    chk("abort_hold_digit", {28'd0, digit}, 32'd7);
    chk("abort_hold_seg", {24'd0, seven_seg}, 32'h07);
    chk("abort_hold_dvalid", {31'd0, digit_valid}, 32'd1);

    pulse_start(1'b0, 16'h0000);
    send_beats(tbl[0].sc, 10);
    check_result("post_abort", 4'd3, 8'h4F, 1'b0);

    // Restart mid-collection; the beat coincident with start is dropped
    sc = '0; sc[1] = 16'h7000;
    pulse_start(1'b0, 16'h0000);
    send_beats(sc, 5);
    pulse_start(1'b1, 16'h7FFF);
    sc = '0; sc[9] = 16'h1000;
    send_beats(sc, 10);
    check_result("restart", 4'd9, 8'h6F, 1'b0);

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_seg", {24'd0, seven_seg}, 32'h00);
    chk("clear_dvalid", {31'd0, digit_valid}, 32'd0);
    chk("clear_digit", {28'd0, digit}, 32'hA);

    // Clear on the RESOLVE edge loses to the new result
    pulse_start(1'b0, 16'h0000);
    send_beats(tbl[1].sc, 10);
    check_result("clr_resolve", 4'd2, 8'h5B, 1'b1);

    // Reset mid-collection discards everything
    pulse_start(1'b0, 16'h0000);
    send_beats(tbl[0].sc, 3);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    chk("midrst_ready_busy", {30'd0, score_ready, busy}, 32'd0);
    chk("midrst_digit", {28'd0, digit}, 32'hA);
    chk("midrst_seg_dvalid", {23'd0, seven_seg, digit_valid}, 32'd0);
    score_valid = 1'b1;
    score_data  = 16'h7000;
    @(negedge clk);
    score_valid = 1'b0;
    chk("midrst_idle_ignores", {29'd0, score_ready, busy, done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
